// File: rtl/serial_tc_decoder.sv
// Bit-serial LSB-first two's-complement receiver presenting sign-magnitude words over valid/ready.
// Optional feature: define TCDEC_MINNEG_EN to add the registered minneg output.
module serial_tc_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             i,
    input  logic             v,
    input  logic             start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag,
    output logic             sign,
    output logic             out_valid,
    output logic             busy,
    output logic             abort,
`ifdef TCDEC_MINNEG_EN
    output logic             minneg,
`endif
    output logic             ovr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_neg;
    logic [CW-1:0]    r_cnt;
    logic             r_q;
    logic [WIDTH-1:0] r_mag;
    logic             r_sign;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_abort;
    logic             r_ovr;

    logic             w_load0;
    logic             w_shift;
    logic             w_last;
    logic             w_abort;
    logic             w_ovr;
    logic             w_release;
    logic             w_neg_bit;
    logic [WIDTH-1:0] w_raw_sh;
    logic [WIDTH-1:0] w_neg_sh;

    // NOTE: state and all registers below update with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load0     = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        w_abort     = 1'b0;
        w_ovr       = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (v && start) begin
                    w_load0     = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (v && start) begin
                    w_load0 = 1'b1;
                    w_abort = 1'b1;
                end else if (v) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    if (v && start) begin
                        w_load0     = 1'b1;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (v && start) begin
                    w_ovr = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Negation on the fly: bits pass unchanged up to and including the first 1, then invert.
    assign w_neg_bit = w_load0 ? i : (i ^ r_q);
    assign w_raw_sh  = {i, r_raw[WIDTH-1:1]};
    assign w_neg_sh  = {w_neg_bit, r_neg[WIDTH-1:1]};

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_raw <= '0;
            r_neg <= '0;
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (w_load0) begin
            r_raw <= {i, {(WIDTH-1){1'b0}}};
            r_neg <= {i, {(WIDTH-1){1'b0}}};
            r_cnt <= CW'(1);
            r_q   <= i;
        end else if (w_shift) begin
            r_raw <= w_raw_sh;
            r_neg <= w_neg_sh;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            r_q   <= r_q | i;
        end
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_mag       <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_mag       <= i ? w_neg_sh : w_raw_sh;
            r_sign      <= i;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt == SHIFT);
            r_abort <= w_abort;
            r_ovr   <= w_ovr;
        end
    end

`ifdef TCDEC_MINNEG_EN
    localparam logic [WIDTH-1:0] MINNEG_WORD = {1'b1, {(WIDTH-1){1'b0}}};
    logic r_minneg;

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n)           r_minneg <= 1'b0;
        else if (w_last)    r_minneg <= (w_raw_sh == MINNEG_WORD);
        else if (w_release) r_minneg <= 1'b0;
    end

    assign minneg = r_minneg;
`endif

    assign mag       = r_mag;
    assign sign      = r_sign;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign abort     = r_abort;
    assign ovr       = r_ovr;

endmodule

// File: doc/serial_tc_decoder.md
# serial_tc_decoder

Bit-serial receiver for the LSB-first two's-complement stream produced by the serial complementer. It shifts in one WIDTH-bit frame, recovers the word in parallel and presents it as sign-magnitude. Raw and negated images are built concurrently, so no post-frame arithmetic is needed. It sits at the consumer end of the serial complement path and hands words to parallel logic over a valid/ready handshake.

## Interface
- WIDTH, 8: frame length in bits; legal range 2 to 32.
- t_clk  input  1  clock; all state changes on rising edge.
- r_n  input  1  asynchronous active-low reset.
- i  input  1  serial data bit; LSB first, MSB (sign) last.
- v  input  1  i is valid this cycle.
- start  input  1  qualifies, with v, the first (LSB) bit of a frame.
- out_ready  input  1  consumer accepts the held result.
- mag  output  WIDTH  magnitude of received word, unsigned.
- sign  output  1  sign of received word (1 = negative).
- out_valid  output  1  mag/sign hold a complete frame.
- busy  output  1  frame in progress.
- abort  output  1  one-cycle pulse: frame restarted before completion.
- ovr  output  1  one-cycle pulse: start bit dropped while holding.

## Operation
- States: IDLE, SHIFT, HOLD. Reset gives IDLE; mag=0, sign=0, out_valid=0, busy=0, abort=0, ovr=0, bit counter=0, seen-one flag q=0.
- A bit is consumed only when v=1. Bits with v=1 and start=0 in IDLE are ignored.
- IDLE: v&start consumes bit 0, goes to SHIFT, counter=1.
- SHIFT: each v bit shifts into raw and neg registers (right shift, insert at MSB). neg bit = i XOR q, using q before update. q then becomes q OR i. q is cleared at every frame start, so bit 0 neg = i.
- SHIFT, v&start: abort=1 for one cycle. The partial frame is discarded and this bit becomes bit 0 of a new frame.
- When the WIDTH-th bit is consumed, go to HOLD. sign is set to that bit. mag is set to neg register if sign=1, else raw, each including the final bit. out_valid=1 and busy=0.
- HOLD: mag, sign and out_valid are stable until out_ready=1, which clears out_valid and returns to IDLE.
- HOLD with out_ready=1 and v&start in the same cycle: handoff completes and the bit is consumed as bit 0 of a new frame (state SHIFT). There is no bubble.
- HOLD with out_ready=0 and v&start: the bit is dropped, ovr=1 for one cycle, and the state stays HOLD. Non-start bits in HOLD are silently ignored.
- Most-negative input -2^(WIDTH-1) gives mag=2^(WIDTH-1), which fits unsigned WIDTH, and sign=1.
- Negative zero is impossible. Input 0 gives mag=0, sign=0.
- r_n low at any time, including mid-frame or in HOLD, immediately forces reset values. The partial frame is lost.

## Timing
- busy=1 from the cycle after bit 0 is consumed until the cycle after the last bit.
- Latency: out_valid rises on the rising edge that consumes bit WIDTH-1, i.e. it is visible in the cycle after the last bit is presented.
- Minimum frame time is WIDTH cycles with v held high. Gaps in v stretch the frame without limit.
- abort and ovr are registered and visible for the cycle after the offending edge.
- Sustained back-to-back throughput is one frame per WIDTH cycles when out_ready is held high.

## Configuration
- TCDEC_MINNEG_EN defined: adds output minneg (1 bit). It is registered with mag and reset 0. It is 1 while out_valid=1 and the word equals -2^(WIDTH-1).
- TCDEC_MINNEG_EN undefined: the port is absent, and no detection logic or register exists. All other behaviour is identical.

## Test plan
- WIDTH=8, send 0xFB (-5) LSB first as 1,1,0,1,1,1,1,1 with v=1 and start on bit 0 -> one cycle after the last bit: out_valid=1, sign=1, mag=0x05.
- Send 0x05 with v gaps of 1–3 cycles between bits -> sign=0, mag=0x05. Values hold with out_ready=0 for 10 cycles, then out_valid drops the cycle after out_ready=1.
- Send 0x80 -> sign=1, mag=0x80, and minneg=1 when TCDEC_MINNEG_EN is defined. Send 0x00 -> sign=0, mag=0x00, minneg=0.
- Start a frame, at bit 4 assert start with new frame 0xFF -> abort pulse. The result is sign=1, mag=0x01, and the partial data is absent.
- Hold out_ready=0 in HOLD and assert v&start -> ovr pulse and the held result is unchanged. Then repeat with out_ready=1 in the same cycle -> no ovr, and the new frame 0x7F completes WIDTH bits later with mag=0x7F.
- Assert r_n=0 mid-frame and in HOLD -> all outputs 0 immediately. The next full frame decodes correctly.
